// File: rtl/can_tx_queue_if.sv
`default_nettype none
// ============================================================================
// Module   : can_tx_queue_if
// Brief    : Host/node-side bundle for the CAN transmit message queue.
// Revision : 1.0 - initial release
// ============================================================================
interface can_tx_queue_if #(
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 8,
  parameter int MAX_RETRY = 16
);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY) + 1;

  logic                 wr_valid;
  logic [DATA_SIZE-1:0] wr_data;
  logic                 wr_ready;
  logic                 flush;
  logic                 data_in_req;
  logic                 Retransmit;
  logic [DATA_SIZE-1:0] In_packet;
  logic [CNT_W-1:0]     count;
  logic                 empty;
  logic                 full;
  logic                 drop_zero;
  logic                 tx_done;
  logic [RETRY_W-1:0]   retry_cnt;
  logic                 retry_abort;

  modport master (
    output wr_valid, wr_data, flush, data_in_req, Retransmit,
    input  wr_ready, In_packet, count, empty, full, drop_zero,
           tx_done, retry_cnt, retry_abort
  );

  modport slave (
    input  wr_valid, wr_data, flush, data_in_req, Retransmit,
    output wr_ready, In_packet, count, empty, full, drop_zero,
           tx_done, retry_cnt, retry_abort
  );
endinterface
`default_nettype wire

// File: rtl/can_tx_queue.sv
`default_nettype none
// ============================================================================
// Module   : can_tx_queue
// Brief    : Circular transmit queue feeding a CAN node, with in-flight frame
//            and retransmit tracking.
// Revision : 1.0 - initial release
// ============================================================================
module can_tx_queue #(
  parameter int DATA_SIZE = 64,
  parameter int DEPTH     = 8,
  parameter int MAX_RETRY = 16
) (
  input  logic          clock,
  input  logic          reset,
  can_tx_queue_if.slave bus
);
  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int RETRY_W = $clog2(MAX_RETRY) + 1;

  localparam logic [CNT_W-1:0]   FULL_COUNT  = CNT_W'(DEPTH);
  localparam logic [RETRY_W-1:0] RETRY_LIMIT = RETRY_W'(MAX_RETRY);

  logic [DATA_SIZE-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               inflight_q, inflight_d;
  logic               retx_prev_q, retx_prev_d;
  logic               drop_zero_q, drop_zero_d;
  logic               tx_done_q, tx_done_d;
  logic [RETRY_W-1:0] retry_cnt_q, retry_cnt_d;
  logic               retry_abort_q, retry_abort_d;

  logic empty;
  logic full;
  logic wr_accept;
  logic push;
  logic pop;
  logic retx_rise;

  // Acceptance is based on registered count only: a same-edge pop never frees a slot early.
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_COUNT);
  assign wr_accept = bus.wr_valid && !full;
  assign push      = wr_accept && (bus.wr_data != '0) && !bus.flush;
  assign pop       = bus.data_in_req && !empty && !bus.flush;
  assign retx_rise = bus.Retransmit && !retx_prev_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // A node request closes the current frame; Retransmit edges only count while a frame is out.
  always_comb begin
    drop_zero_d   = wr_accept && (bus.wr_data == '0);
    tx_done_d     = bus.data_in_req && inflight_q;
    retx_prev_d   = bus.Retransmit;
    inflight_d    = inflight_q;
    retry_cnt_d   = retry_cnt_q;
    retry_abort_d = 1'b0;
    if (bus.data_in_req) begin
      inflight_d  = !empty;
      retry_cnt_d = '0;
    end else if (retx_rise && inflight_q && (retry_cnt_q != RETRY_LIMIT)) begin
      retry_cnt_d   = retry_cnt_q + RETRY_W'(1);
      retry_abort_d = (retry_cnt_d == RETRY_LIMIT);
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      retx_prev_q   <= 1'b0;
      drop_zero_q   <= 1'b0;
      tx_done_q     <= 1'b0;
      retry_cnt_q   <= '0;
      retry_abort_q <= 1'b0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      retx_prev_q   <= retx_prev_d;
      drop_zero_q   <= drop_zero_d;
      tx_done_q     <= tx_done_d;
      retry_cnt_q   <= retry_cnt_d;
      retry_abort_q <= retry_abort_d;
    end
  end

  assign bus.wr_ready    = !full;
  assign bus.In_packet   = empty ? '0 : mem_q[rd_ptr_q];
  assign bus.count       = count_q;
  assign bus.empty       = empty;
  assign bus.full        = full;
  assign bus.drop_zero   = drop_zero_q;
  assign bus.tx_done     = tx_done_q;
  assign bus.retry_cnt   = retry_cnt_q;
  assign bus.retry_abort = retry_abort_q;

endmodule
`default_nettype wire

// File: tb/tb_can_tx_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_can_tx_queue
// Brief    : Directed and randomized bench for can_tx_queue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_can_tx_queue;
  localparam int DATA_SIZE = 64;
  localparam int DEPTH     = 8;
  localparam int MAX_RETRY = 16;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  can_tx_queue_if #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) bus ();

  can_tx_queue #(.DATA_SIZE(DATA_SIZE), .DEPTH(DEPTH), .MAX_RETRY(MAX_RETRY)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a plain FIFO of packets plus frame-level bookkeeping.
  logic [63:0] mq[$];
  bit m_inflight = 0;
  bit m_prev     = 0;
  bit m_drop     = 0;
  bit m_done     = 0;
  bit m_abort    = 0;
  int m_retry    = 0;

  always @(posedge clock) begin
    bit was_empty;
    bit was_full;
    was_empty = (mq.size() == 0);
    was_full  = (mq.size() == DEPTH);
    if (!reset) begin
      mq.delete();
      m_inflight = 0;
      m_prev     = 0;
      m_drop     = 0;
      m_done     = 0;
      m_abort    = 0;
      m_retry    = 0;
    end else begin
      m_drop  = bus.wr_valid && !was_full && (bus.wr_data == 0);
      m_done  = bus.data_in_req && m_inflight;
      m_abort = 0;
      if (bus.data_in_req) begin
        m_inflight = !was_empty;
        m_retry    = 0;
      end else if (bus.Retransmit && !m_prev && m_inflight && m_retry < MAX_RETRY) begin
        m_retry++;
        m_abort = (m_retry == MAX_RETRY);
      end
      m_prev = bus.Retransmit;
      if (bus.flush) begin
        mq.delete();
      end else begin
        if (bus.data_in_req && !was_empty) void'(mq.pop_front());
        if (bus.wr_valid && !was_full && bus.wr_data != 0) mq.push_back(bus.wr_data);
      end
    end
  end

  always @(posedge clock) begin
    #1;
    begin
      logic [63:0] exp_head;
      exp_head = (mq.size() == 0) ? 64'h0 : mq[0];
      check("In_packet", bus.In_packet, exp_head);
      check("count", 64'(bus.count), 64'(mq.size()));
      check("empty", 64'(bus.empty), 64'(mq.size() == 0));
      check("full", 64'(bus.full), 64'(mq.size() == DEPTH));
      check("wr_ready", 64'(bus.wr_ready), 64'(mq.size() != DEPTH));
      check("drop_zero", 64'(bus.drop_zero), 64'(m_drop));
      check("tx_done", 64'(bus.tx_done), 64'(m_done));
      check("retry_cnt", 64'(bus.retry_cnt), 64'(m_retry));
      check("retry_abort", 64'(bus.retry_abort), 64'(m_abort));
    end
  end

  task automatic idle();
    bus.wr_valid    = 1'b0;
    bus.wr_data     = '0;
    bus.flush       = 1'b0;
    bus.data_in_req = 1'b0;
    bus.Retransmit  = 1'b0;
  endtask

  task automatic push(input logic [63:0] d);
    bus.wr_valid = 1'b1;
    bus.wr_data  = d;
    @(negedge clock);
    bus.wr_valid = 1'b0;
    bus.wr_data  = '0;
  endtask

  task automatic req_pulse(input logic [63:0] head, input logic done);
    bus.data_in_req = 1'b1;
    check("req_head", bus.In_packet, head);
    @(negedge clock);
    bus.data_in_req = 1'b0;
    check("req_tx_done", 64'(bus.tx_done), 64'(done));
    repeat (3) @(negedge clock);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_in_packet"}, bus.In_packet, 64'h0);
    check({tag, "_empty"}, 64'(bus.empty), 64'd1);
    check({tag, "_wr_ready"}, 64'(bus.wr_ready), 64'd1);
    check({tag, "_count"}, 64'(bus.count), 64'd0);
    check({tag, "_pulses"}, {61'd0, bus.tx_done, bus.drop_zero, bus.retry_abort}, 64'd0);
    check({tag, "_retry"}, 64'(bus.retry_cnt), 64'd0);
  endtask

  initial begin
    int aborts;
    int req_div;
    idle();

    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_state("reset");
    reset = 1'b1;

    push(64'h11);
    push(64'h22);
    push(64'h33);
    req_pulse(64'h11, 1'b0);
    req_pulse(64'h22, 1'b1);
    req_pulse(64'h33, 1'b1);
    check("drained_head", bus.In_packet, 64'h0);
    check("drained_count", 64'(bus.count), 64'd0);

    for (int i = 0; i < DEPTH; i++) push(64'h100 + 64'(i));
    check("full_flag", 64'(bus.full), 64'd1);
    check("full_ready", 64'(bus.wr_ready), 64'd0);
    bus.wr_valid    = 1'b1;
    bus.wr_data     = 64'h99;
    bus.data_in_req = 1'b1;
    @(negedge clock);
    bus.data_in_req = 1'b0;
    check("full_pop_count", 64'(bus.count), 64'd7);
    check("full_pop_head", bus.In_packet, 64'h101);
    @(negedge clock);
    bus.wr_valid = 1'b0;
    check("refill_count", 64'(bus.count), 64'd8);
    for (int i = 0; i < DEPTH; i++) begin
      bus.data_in_req = 1'b1;
      check("wrap_head", bus.In_packet, (i < 7) ? 64'h101 + 64'(i) : 64'h99);
      @(negedge clock);
    end
    bus.data_in_req = 1'b0;
    check("wrap_empty", 64'(bus.empty), 64'd1);

    push(64'h0);
    check("zero_drop", 64'(bus.drop_zero), 64'd1);
    check("zero_count", 64'(bus.count), 64'd0);
    @(negedge clock);
    check("zero_drop_end", 64'(bus.drop_zero), 64'd0);

    push(64'hAA);
    bus.data_in_req = 1'b1;
    check("retry_head", bus.In_packet, 64'hAA);
    @(negedge clock);
    bus.data_in_req = 1'b0;
    aborts = 0;
    for (int i = 0; i < MAX_RETRY + 2; i++) begin
      bus.Retransmit = 1'b1;
      @(negedge clock);
      aborts += int'(bus.retry_abort);
      bus.Retransmit = 1'b0;
      @(negedge clock);
      aborts += int'(bus.retry_abort);
      if (i == 7) check("retry_mid", 64'(bus.retry_cnt), 64'd8);
    end
    check("retry_sat", 64'(bus.retry_cnt), 64'd16);
    check("abort_once", 64'(aborts), 64'd1);
    bus.data_in_req = 1'b1;
    @(negedge clock);
    bus.data_in_req = 1'b0;
    check("retry_done", 64'(bus.tx_done), 64'd1);
    check("retry_clear", 64'(bus.retry_cnt), 64'd0);

    for (int i = 1; i <= 5; i++) push(64'(i) << 8);
    check("pre_flush_count", 64'(bus.count), 64'd5);
    bus.flush    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_data  = 64'h55;
    @(negedge clock);
    idle();
    check("flush_count", 64'(bus.count), 64'd0);
    check("flush_empty", 64'(bus.empty), 64'd1);
    check("flush_head", bus.In_packet, 64'h0);

    push(64'h1234);
    push(64'h5678);
    bus.wr_valid = 1'b1;
    bus.wr_data  = 64'h77;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    idle();
    check_reset_state("midreset");
    reset = 1'b1;

    // Alternate busy and quiet request phases so retries can reach saturation.
    req_div = 3;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc % 200 == 0) req_div = ($urandom_range(0, 1) == 0) ? 3 : 60;
      bus.wr_valid    = ($urandom_range(0, 9) < 6);
      bus.wr_data     = ($urandom_range(0, 15) == 0) ? 64'h0 : {$urandom, $urandom};
      bus.data_in_req = ($urandom_range(0, req_div - 1) == 0);
      bus.flush       = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 2) == 0) bus.Retransmit = ~bus.Retransmit;
      reset           = ($urandom_range(0, 499) != 0);
      @(negedge clock);
    end
    idle();
    reset = 1'b1;
    repeat (2) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
